// File: rtl/seq_signed_divider.sv
// rtl/seq_signed_divider.sv - multi-cycle signed restoring divider with start/busy/done handshake
module seq_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     quotient,
    output logic [WIDTH-1:0]     remainder,
    output logic [2*WIDTH-1:0]   quotient_ext,
    output logic                 div0,
    output logic                 ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 sq_q, sq_d;
    logic                 sr_q, sr_d;
    logic                 div0_pend_q, div0_pend_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic [2*WIDTH-1:0]   quotient_ext_q, quotient_ext_d;
    logic                 div0_q, div0_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH-1:0]     a_mag;
    logic [WIDTH-1:0]     b_mag;
    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     q_fix;

    // Magnitudes are unsigned, so the most-negative operand maps to 2^(WIDTH-1) exactly.
    assign a_mag   = dividend[WIDTH-1] ? -dividend : dividend;
    assign b_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign shifted = {rem_q, q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dvs_q};
    // With a zero divisor every trial succeeds, leaving q all ones and rem = |dividend|.
    assign q_fix   = div0_pend_q ? {WIDTH{1'b1}} : (sq_q ? -q_q : q_q);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rem_d          = rem_q;
        q_d            = q_q;
        dvs_d          = dvs_q;
        sq_d           = sq_q;
        sr_d           = sr_q;
        div0_pend_d    = div0_pend_q;
        ovf_pend_d     = ovf_pend_q;
        busy_d         = busy_q;
        done_d         = done_q;
        quotient_d     = quotient_q;
        remainder_d    = remainder_q;
        quotient_ext_d = quotient_ext_q;
        div0_d         = div0_q;
        ovf_d          = ovf_q;
        case (state_q)
            IDLE: begin
                done_d = 1'b0;
                // The done cycle is spent in IDLE, so a start seen alongside done is dropped.
                if (start && !done_q) begin
                    state_d     = DIV;
                    busy_d      = 1'b1;
                    cnt_d       = '0;
                    rem_d       = '0;
                    q_d         = a_mag;
                    dvs_d       = b_mag;
                    sq_d        = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    sr_d        = dividend[WIDTH-1];
                    div0_pend_d = (divisor == '0);
                    ovf_pend_d  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) &&
                                  (divisor == {WIDTH{1'b1}});
                end
            end
            DIV: begin
                q_d   = {q_q[WIDTH-2:0], ~trial[WIDTH]};
                rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d     = q_fix;
                remainder_d    = sr_q ? -rem_q : rem_q;
                quotient_ext_d = {{WIDTH{q_fix[WIDTH-1]}}, q_fix};
                div0_d         = div0_pend_q;
                ovf_d          = ovf_pend_q;
                done_d         = 1'b1;
                busy_d         = 1'b0;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rem_q          <= '0;
            q_q            <= '0;
            dvs_q          <= '0;
            sq_q           <= 1'b0;
            sr_q           <= 1'b0;
            div0_pend_q    <= 1'b0;
            ovf_pend_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            quotient_ext_q <= '0;
            div0_q         <= 1'b0;
            ovf_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rem_q          <= rem_d;
            q_q            <= q_d;
            dvs_q          <= dvs_d;
            sq_q           <= sq_d;
            sr_q           <= sr_d;
            div0_pend_q    <= div0_pend_d;
            ovf_pend_q     <= ovf_pend_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            quotient_q     <= quotient_d;
            remainder_q    <= remainder_d;
            quotient_ext_q <= quotient_ext_d;
            div0_q         <= div0_d;
            ovf_q          <= ovf_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign quotient     = quotient_q;
    assign remainder    = remainder_q;
    assign quotient_ext = quotient_ext_q;
    assign div0         = div0_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// tb/tb_seq_signed_divider.sv - directed-vector bench for seq_signed_divider
module tb_seq_signed_divider;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic [15:0] quotient_ext;
    logic        div0;
    logic        ovf;

    int total;
    int bad;

    seq_signed_divider #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .dividend     (dividend),
        .divisor      (divisor),
        .busy         (busy),
        .done         (done),
        .quotient     (quotient),
        .remainder    (remainder),
        .quotient_ext (quotient_ext),
        .div0         (div0),
        .ovf          (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // n counts cycles after the accept edge; done is expected in cycle 10, busy in 1..9.
    task automatic run_div(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] eq, input logic [7:0] er, input logic [15:0] ex,
                           input logic ed0, input logic eov, input int pulse_at, input int last_n);
        int dones;
        int first;
        int busy_err;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        dones    = 0;
        first    = 0;
        busy_err = 0;
        for (int n = 1; n <= last_n; n++) begin
            if (busy !== (n <= 9)) busy_err++;
            if (done === 1'b1) begin
                dones++;
                if (first == 0) first = n;
            end
            start = (n == pulse_at);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk({tag, "_busy"}, 32'(busy_err), 32'd0);
        chk({tag, "_lat"}, 32'(first), 32'd10);
        chk({tag, "_ndone"}, 32'(dones), 32'd1);
        chk({tag, "_q"}, {24'd0, quotient}, {24'd0, eq});
        chk({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
        chk({tag, "_qext"}, {16'd0, quotient_ext}, {16'd0, ex});
        chk({tag, "_div0"}, {31'd0, div0}, {31'd0, ed0});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, eov});
    endtask

    initial begin
        int dones;
        total    = 0;
        bad      = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        #13;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {24'd0, quotient}, 32'd0);
        chk("rst_r", {24'd0, remainder}, 32'd0);
        chk("rst_qext", {16'd0, quotient_ext}, 32'd0);
        chk("rst_flags", {30'd0, div0, ovf}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div("p100_7",   8'd100, 8'd7,   8'h0E, 8'h02, 16'h000E, 1'b0, 1'b0, 0, 14);
        run_div("m100_7",   8'h9C,  8'd7,   8'hF2, 8'hFE, 16'hFFF2, 1'b0, 1'b0, 0, 14);
        run_div("p100_m7",  8'd100, 8'hF9,  8'hF2, 8'h02, 16'hFFF2, 1'b0, 1'b0, 0, 14);
        run_div("m128_m1",  8'h80,  8'hFF,  8'h80, 8'h00, 16'hFF80, 1'b0, 1'b1, 0, 14);
        run_div("m128_p1",  8'h80,  8'h01,  8'h80, 8'h00, 16'hFF80, 1'b0, 1'b0, 0, 14);
        run_div("p5_z",     8'd5,   8'h00,  8'hFF, 8'h05, 16'hFFFF, 1'b1, 1'b0, 0, 14);
        run_div("m5_z",     8'hFB,  8'h00,  8'hFF, 8'hFB, 16'hFFFF, 1'b1, 1'b0, 0, 14);
        run_div("m100_m7",  8'h9C,  8'hF9,  8'h0E, 8'hFE, 16'h000E, 1'b0, 1'b0, 4, 14);
        run_div("p127_3a",  8'd127, 8'd3,   8'h2A, 8'h01, 16'h002A, 1'b0, 1'b0, 10, 14);
        run_div("p80_9",    8'd80,  8'd9,   8'h08, 8'h08, 16'h0008, 1'b0, 1'b0, 0, 10);
        @(posedge clk);
        run_div("p127_3b",  8'd127, 8'd3,   8'h2A, 8'h01, 16'h002A, 1'b0, 1'b0, 0, 14);

        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_done", {31'd0, done}, 32'd0);
        chk("arst_q", {24'd0, quotient}, 32'd0);
        chk("arst_r", {24'd0, remainder}, 32'd0);
        chk("arst_qext", {16'd0, quotient_ext}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int n = 0; n < 14; n++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dones++;
        end
        chk("arst_nodone", 32'(dones), 32'd0);

        run_div("z_m3",     8'h00,  8'hFD,  8'h00, 8'h00, 16'h0000, 1'b0, 1'b0, 0, 14);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
